// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

   localparam int XLEN = 32;
   localparam int ILEN = 32;

   localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h8000_0000;
   localparam logic [ILEN-1:0] NOP_INSTR        = 32'h0000_0013;

   // One fetched instruction together with the address it came from.
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and occupancy count, used for fetch bookkeeping.
// Latency: a pushed word becomes visible at the head one cycle after the push.
// Backpressure: none internal; a push while full is ignored unless a pop happens the same cycle.
module fetch_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & ~flush & (~full | pop_ok);
   assign head    = mem[rd_ptr];

   // Storage is written only on an accepted push; contents are don't-care when empty.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy update; flush discards everything in one edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(push_ok) - CW'(pop_ok);
      end
   end

endmodule

// File: rtl/if_fetch_unit.sv
// Pipelined instruction fetch: issues word requests, tracks them in flight, buffers results for ID.
// Latency: request accepted at N, response at N+L, instruction visible to ID at N+L+1.
// Backpressure: credit limit (in flight + buffered <= DEPTH) stops issue; responses are never refused.
module if_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int              DEPTH    = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [ILEN-1:0] imem_rsp_data,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] id_pc,
   output logic [ILEN-1:0] id_instr
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] CREDITS = DEPTH[CW:0];

   logic [XLEN-1:0] fetch_pc;
   logic [CW-1:0]   drop_cnt;
   logic [CW-1:0]   inflight;
   logic [CW-1:0]   buf_count;
   logic [CW:0]     credit_used;
   logic            started;
   logic            pop;
   logic            issue;
   logic            req_fire;
   logic            rsp_keep;
   logic [XLEN-1:0] inflight_pc;
   fetch_entry_t    buf_push;
   fetch_entry_t    buf_head;
   logic            pcq_empty;
   logic            pcq_full;
   logic            buf_empty;
   logic            buf_full;
   logic            unused_bits;

   // A redirect suppresses the pop so the flushed head is not also consumed.
   assign pop         = id_valid & id_ready & ~redirect_valid;
   assign credit_used = {1'b0, inflight} + {1'b0, buf_count} - {{CW{1'b0}}, pop};
   assign issue       = started & ~redirect_valid & (credit_used < CREDITS);
   assign req_fire    = issue & imem_req_ready;

   // Responses belonging to an abandoned path are discarded, including one landing on the redirect edge.
   assign rsp_keep = imem_rsp_valid & ~redirect_valid & (drop_cnt == '0);
   assign buf_push = '{pc: inflight_pc, instr: imem_rsp_data};

   assign imem_req_valid = issue;
   assign imem_req_addr  = fetch_pc;
   assign id_valid       = ~buf_empty;
   assign id_pc          = id_valid ? buf_head.pc : '0;
   assign id_instr       = id_valid ? buf_head.instr : '0;

   assign unused_bits = ^{redirect_pc[1:0], pcq_full, buf_full};

   fetch_fifo #(
      .WIDTH (XLEN),
      .DEPTH (DEPTH)
   ) u_inflight_q (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (1'b0),
      .push      (req_fire),
      .push_data (fetch_pc),
      .pop       (imem_rsp_valid),
      .head      (inflight_pc),
      .count     (inflight),
      .empty     (pcq_empty),
      .full      (pcq_full)
   );

   fetch_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (DEPTH)
   ) u_out_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (redirect_valid),
      .push      (rsp_keep),
      .push_data (buf_push),
      .pop       (pop),
      .head      (buf_head),
      .count     (buf_count),
      .empty     (buf_empty),
      .full      (buf_full)
   );

   // Holds off issue for the edge on which reset is released so no request is visible in reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         started <= 1'b0;
      end else begin
         started <= 1'b1;
      end
   end

   // Fetch PC: a redirect overrides the sequential advance of an accepted request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc <= RESET_PC;
      end else if (redirect_valid) begin
         fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      end else if (req_fire) begin
         fetch_pc <= fetch_pc + PC_STEP;
      end
   end

   // On redirect every request still outstanding after this edge is stale: that is the previous
   // drop count plus the live requests, i.e. the whole in-flight queue minus any response popping now.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt <= '0;
      end else if (redirect_valid) begin
         drop_cnt <= inflight - CW'(imem_rsp_valid);
      end else if (imem_rsp_valid && (drop_cnt != '0)) begin
         drop_cnt <= drop_cnt - CW'(1);
      end
   end

   // Memory must never answer without an outstanding request.
   rsp_without_req: assert property (@(posedge clk) disable iff (!rst_n)
      !(imem_rsp_valid && pcq_empty));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed and random stimulus for if_fetch_unit with an in-order memory model and PC scoreboard.
// Latency: inputs driven on the falling edge, outputs sampled 1 time unit later.
// Backpressure: id_ready and imem_req_ready driven per step, fixed or random.
module tb_if_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h8000_0000;
   localparam int          DEPTH  = 4;

   typedef struct {
      int          due;
      logic [31:0] addr;
   } mreq_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_pc;
   logic [31:0] id_instr;

   int          checks;
   int          errors;
   int          cyc;
   int          fires;
   int          pops;
   int          first_fire;
   int          first_valid;
   int          last_due;
   int          lat_min;
   int          lat_max;
   int          rel;
   int          r;
   int          pops_before;
   logic        rand_mode;
   logic        have_pop;
   logic [31:0] exp_pc;
   logic [31:0] first_fire_addr;
   logic [31:0] first_pop_pc;
   logic        drv_redirect;
   logic [31:0] drv_redirect_pc;
   logic        drv_id_ready;
   logic        drv_req_ready;

   mreq_t       mem_q[$];
   logic [31:0] sb[$];
   logic [31:0] fire_log[$];

   always #5 clk = ~clk;

   if_fetch_unit #(
      .RESET_PC (RST_PC),
      .DEPTH    (DEPTH)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_pc          (id_pc),
      .id_instr       (id_instr)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] rot;
      rot = {a[15:0], a[31:16]};
      return (a ^ 32'h5A5A_1234) + rot;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      mem_q.delete();
      sb.delete();
      fire_log.delete();
      exp_pc      = RST_PC;
      fires       = 0;
      pops        = 0;
      first_fire  = -1;
      first_valid = -1;
      last_due    = -1;
      have_pop    = 1'b0;
      first_pop_pc    = '0;
      first_fire_addr = '0;
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      drv_redirect   = 1'b0;
      drv_id_ready   = 1'b0;
      drv_req_ready  = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      id_ready       = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      clear_model();
      @(negedge clk);
      #1;
      check("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check("rst_req_addr", imem_req_addr, RST_PC);
      check("rst_id_valid", 32'(id_valid), 32'd0);
      check("rst_id_pc", id_pc, 32'd0);
      check("rst_id_instr", id_instr, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One clock cycle: drive inputs, let them settle, score the handshakes, advance to next falling edge.
   task automatic step();
      mreq_t       m;
      logic        fire;
      logic        popv;
      logic [31:0] e;
      int          lat;
      int          due;
      if (rand_mode) begin
         drv_req_ready = ($urandom_range(0, 3) != 0);
         drv_id_ready  = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 19) == 0) begin
            drv_redirect    = 1'b1;
            drv_redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + $urandom_range(0, 15))
                                                          : $urandom;
         end
      end
      redirect_valid = drv_redirect;
      redirect_pc    = drv_redirect_pc;
      id_ready       = drv_id_ready;
      imem_req_ready = drv_req_ready;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
         m = mem_q.pop_front();
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(m.addr);
      end
      #1;
      fire = imem_req_valid & imem_req_ready;
      popv = id_valid & id_ready & ~redirect_valid;
      if (redirect_valid) begin
         check("no_req_on_redirect", 32'(imem_req_valid), 32'd0);
      end
      if (fire) begin
         check("req_addr", imem_req_addr, exp_pc);
         if (first_fire < 0) begin
            first_fire      = cyc;
            first_fire_addr = imem_req_addr;
         end
         fire_log.push_back(imem_req_addr);
         lat = int'($urandom_range(lat_min, lat_max));
         due = cyc + lat;
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         m.due  = due;
         m.addr = imem_req_addr;
         mem_q.push_back(m);
         sb.push_back(exp_pc);
         exp_pc = exp_pc + 32'd4;
         fires++;
      end
      if (id_valid && first_valid < 0) first_valid = cyc;
      if (popv) begin
         check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("id_pc", id_pc, e);
            check("id_instr", id_instr, mem_word(e));
         end
         if (!have_pop) begin
            have_pop     = 1'b1;
            first_pop_pc = id_pc;
         end
         pops++;
      end
      if (redirect_valid) begin
         sb.delete();
         fire_log.delete();
         exp_pc       = {redirect_pc[31:2], 2'b00};
         first_fire   = -1;
         first_valid  = -1;
         have_pop     = 1'b0;
         first_pop_pc = '0;
      end
      drv_redirect = 1'b0;
      @(negedge clk);
      cyc++;
   endtask

   initial begin
      checks = 0; errors = 0; cyc = 0;
      rand_mode = 1'b0; lat_min = 1; lat_max = 1;
      drv_redirect_pc = '0;
      @(negedge clk);

      // Streaming from reset, L=1, ID always ready.
      do_reset();
      rel = cyc;
      drv_id_ready = 1'b1; drv_req_ready = 1'b1;
      repeat (14) step();
      check("t1_first_req_soon", 32'(first_fire >= rel && first_fire <= rel + 1), 32'd1);
      check("t1_first_req_addr", first_fire_addr, RST_PC);
      check("t1_latency", 32'(first_valid - first_fire), 32'd2);
      check("t1_no_gaps", 32'(pops), 32'(cyc - first_valid));

      // ID stall: credit limit caps issue, head held, then gap-free drain.
      do_reset();
      drv_id_ready = 1'b0; drv_req_ready = 1'b1;
      repeat (10) step();
      check("t2_req_count", 32'(fires), 32'(DEPTH));
      check("t2_req_valid_held", 32'(imem_req_valid), 32'd0);
      check("t2_head_valid", 32'(id_valid), 32'd1);
      check("t2_head_pc", id_pc, RST_PC);
      drv_id_ready = 1'b1;
      repeat (8) step();
      check("t2_drain_no_gap", 32'(pops), 32'd8);

      // Redirect with two responses in flight, L=3.
      do_reset();
      lat_min = 3; lat_max = 3;
      drv_id_ready = 1'b1; drv_req_ready = 1'b0;
      step();
      drv_req_ready = 1'b1;
      step(); step();
      drv_req_ready = 1'b0;
      check("t3_inflight", 32'(fires), 32'd2);
      drv_redirect = 1'b1; drv_redirect_pc = 32'h8000_0103; drv_req_ready = 1'b1;
      r = cyc;
      step();
      check("t3_id_valid_after", 32'(id_valid), 32'd0);
      repeat (8) step();
      check("t3_first_req_cycle", 32'(first_fire), 32'(r + 1));
      check("t3_first_req_addr", first_fire_addr, 32'h8000_0100);
      check("t3_first_valid_cycle", 32'(first_valid), 32'(r + 5));
      check("t3_first_id_pc", first_pop_pc, 32'h8000_0100);

      // Redirect coinciding with a response and with id_ready.
      do_reset();
      lat_min = 1; lat_max = 1;
      drv_id_ready = 1'b0; drv_req_ready = 1'b0;
      step();
      drv_req_ready = 1'b1;
      step(); step();
      check("t4_id_valid_before", 32'(id_valid), 32'd1);
      check("t4_rsp_pending", 32'(mem_q.size()), 32'd1);
      drv_redirect = 1'b1; drv_redirect_pc = 32'h8000_0200; drv_id_ready = 1'b1;
      r = cyc;
      step();
      check("t4_id_valid_after", 32'(id_valid), 32'd0);
      repeat (6) step();
      check("t4_first_valid_cycle", 32'(first_valid), 32'(r + 3));
      check("t4_first_id_pc", first_pop_pc, 32'h8000_0200);

      // Address wrap at the top of the address space.
      drv_redirect = 1'b1; drv_redirect_pc = 32'hFFFF_FFF8;
      drv_id_ready = 1'b1; drv_req_ready = 1'b1;
      repeat (9) step();
      check("t5_fire_count", 32'(fire_log.size() >= 3), 32'd1);
      check("t5_pre_wrap", fire_log[1], 32'hFFFF_FFFC);
      check("t5_wrap_addr", fire_log[2], 32'h0000_0000);

      // Random handshakes, latencies 1-5 and redirects.
      rand_mode = 1'b1; lat_min = 1; lat_max = 5;
      pops_before = pops;
      repeat (400) step();
      rand_mode = 1'b0;
      check("t6_progress", 32'(pops - pops_before >= 40), 32'd1);

      // Asynchronous reset pulse mid-stream.
      drv_id_ready = 1'b1; drv_req_ready = 1'b1; drv_redirect = 1'b0;
      lat_min = 2; lat_max = 2;
      repeat (10) step();
      check("t7_valid_before_rst", 32'(id_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      imem_rsp_valid = 1'b0;
      #1;
      check("t7_async_id_valid", 32'(id_valid), 32'd0);
      check("t7_async_req_valid", 32'(imem_req_valid), 32'd0);
      check("t7_async_req_addr", imem_req_addr, RST_PC);
      @(negedge clk);
      do_reset();
      drv_id_ready = 1'b1; drv_req_ready = 1'b1;
      repeat (6) step();
      check("t7_restart_req", 32'(first_fire >= 0), 32'd1);
      check("t7_restart_addr", first_fire_addr, RST_PC);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
